// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared width and FSM state types for the load/store unit
package load_store_unit_pkg;
  typedef enum logic [1:0] {BITS8 = 2'b00, BITS16 = 2'b01, BITS32 = 2'b10} MemWidth;
  typedef enum logic [1:0] {IDLE, XFER, DONE} LsuState;
endpackage

// File: rtl/load_store_unit_load_extender.sv
// load_extender: sign/zero extends an assembled load word to 32 bits
import load_store_unit_pkg::*;
module load_extender (
  input  logic [31:0] acc,
  input  logic [1:0]  width,
  input  logic        is_unsigned,
  output logic [31:0] result
);
  logic sign;
  assign sign = ~is_unsigned & (width == BITS8 ? acc[7] : acc[15]);
  assign result = width == BITS8 ? {{24{sign}}, acc[7:0]} :
                  width == BITS16 ? {{16{sign}}, acc[15:0]} : acc;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte-serial RISC-V load/store engine; define LSU_MISALIGN_CHECK_EN to reject misaligned half/word
import load_store_unit_pkg::*;
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              write,
  input  logic [1:0]        width,
  input  logic              is_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);
  LsuState           state;
  logic [1:0]        idx, last, width_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, acc, acc_nx, ext;
  logic              write_q, uns_q, accept, bad;
  assign accept = req & (state == IDLE | state == DONE);
`ifdef LSU_MISALIGN_CHECK_EN
  assign bad = width == 2'b11 | (width == BITS16 & addr[0]) | (width == BITS32 & addr[1:0] != 2'b00);
`else
  assign bad = width == 2'b11;
`endif
  assign last = width_q == BITS8 ? 2'd0 : width_q == BITS16 ? 2'd1 : 2'd3;
  assign busy = state == XFER;
  assign mem_we = busy & write_q;
  assign mem_addr = busy ? addr_q + ADDR_W'(idx) : '0;
  assign mem_wdata = busy ? 8'(wdata_q >> {idx, 3'b000}) : '0;
  // merge the byte currently on the bus so the final edge sees the complete word
  always_comb begin
    acc_nx = acc;
    acc_nx[{idx, 3'b000} +: 8] = mem_rdata;
  end
  load_extender u_ext (.acc(acc_nx), .width(width_q), .is_unsigned(uns_q), .result(ext));
  // request latch, byte sequencing and completion flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      width_q <= '0;
      uns_q <= 1'b0;
      acc <= '0;
      rdata <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else if (accept) begin
      addr_q <= addr;
      wdata_q <= wdata;
      write_q <= write;
      width_q <= width;
      uns_q <= is_unsigned;
      idx <= '0;
      state <= bad ? DONE : XFER;
      done <= bad;
      err <= bad;
    end else if (state == XFER) begin
      if (!write_q) acc <= acc_nx;
      if (idx == last) begin
        state <= DONE;
        done <= 1'b1;
        err <= 1'b0;
        if (!write_q) rdata <= ext;
      end else begin
        idx <= idx + 2'd1;
      end
    end else if (state == DONE) begin
      state <= IDLE;
      done <= 1'b0;
      err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed transactions checked every cycle against a transaction-level model
module tb_load_store_unit;
  logic clk = 1'b0, rst_n, req, write, is_unsigned, busy, done, err, mem_we;
  logic [1:0] width;
  logic [31:0] addr, wdata, rdata, mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic [7:0] ram [1024];
  logic [7:0] ref_mem [1024];
  logic ld_en;
  logic [9:0] ld_a;
  logic [7:0] ld_d;
  int cyc = 0, n_vec = 0, n_bad = 0;
  bit chk_en = 0;
  logic [31:0] m_rdata = '0;
  typedef struct {int cyc; logic busy, done, err, we, load; logic [31:0] addr; logic [7:0] wd; logic [31:0] rd;} exp_t;
  exp_t q[$];
  exp_t ce;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .write(write), .width(width),
    .is_unsigned(is_unsigned), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .rdata(rdata), .err(err), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_rdata = ram[mem_addr[9:0]];
  always @(posedge clk) begin
    if (ld_en) ram[ld_a] <= ld_d;
    else if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    if (q.size() > 0 && q[0].cyc == cyc) ce = q.pop_front();
    else ce = '{cyc: cyc, busy: 0, done: 0, err: 0, we: 0, load: 0, addr: 0, wd: 0, rd: 0};
    if (ce.done && ce.load) m_rdata = ce.rd;
    chk("busy", 32'(busy), 32'(ce.busy));
    chk("done", 32'(done), 32'(ce.done));
    chk("err", 32'(err), 32'(ce.err));
    chk("mem_we", 32'(mem_we), 32'(ce.we));
    chk("rdata", rdata, m_rdata);
    if (ce.busy) chk("mem_addr", mem_addr, ce.addr);
    if (ce.we) chk("mem_wdata", 32'(mem_wdata), 32'(ce.wd));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_a = a; ld_d = d; ref_mem[a] = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic issue(input logic w, input logic [1:0] wd, input logic u, input logic [31:0] a,
                       input logic [31:0] d, output int dc);
    int n;
    bit bad;
    logic [31:0] raw, v;
    n = wd == 2'd0 ? 1 : wd == 2'd1 ? 2 : 4;
    bad = wd == 2'd3;
`ifdef LSU_MISALIGN_CHECK_EN
    bad = bad || (wd == 2'd1 && a[0]) || (wd == 2'd2 && a[1:0] != 2'd0);
`endif
    req = 1'b1; write = w; width = wd; is_unsigned = u; addr = a; wdata = d;
    raw = '0;
    if (!bad) for (int i = 0; i < n; i++) begin
      q.push_back('{cyc: cyc + 1 + i, busy: 1, done: 0, err: 0, we: w, load: 0,
                    addr: a + 32'(i), wd: 8'(d >> (8 * i)), rd: 0});
      raw |= 32'(ref_mem[10'(a + 32'(i))]) << (8 * i);
      if (w) ref_mem[10'(a + 32'(i))] = 8'(d >> (8 * i));
    end
    if (n == 1) v = (!u && raw >= 128) ? raw - 32'd256 : raw;
    else if (n == 2) v = (!u && raw >= 32768) ? raw - 32'd65536 : raw;
    else v = raw;
    dc = cyc + 1 + (bad ? 0 : n);
    q.push_back('{cyc: dc, busy: 0, done: 1, err: bad, we: 0, load: !w && !bad, addr: 0, wd: 0, rd: v});
  endtask

  task automatic txn(input logic w, input logic [1:0] wd, input logic u, input logic [31:0] a, input logic [31:0] d);
    int dc;
    issue(w, wd, u, a, d, dc);
    step();
    req = 1'b0;
    while (cyc < dc) step();
  endtask

  initial begin
    int dc;
    rst_n = 1'b0; req = 1'b0; write = 1'b0; width = '0; is_unsigned = 1'b0;
    addr = '0; wdata = '0; ld_en = 1'b0; ld_a = '0; ld_d = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 1024; i++) preload(10'(i), 8'h00);
    preload(10'h100, 8'h80);
    preload(10'h102, 8'h34); preload(10'h103, 8'h12);
    preload(10'h104, 8'h80); preload(10'h105, 8'hFF);
    for (int i = 0; i < 4; i++) preload(10'(32'h79 + 32'(i)), 8'h11);
    preload(10'h200, 8'hAA); preload(10'h201, 8'hBB); preload(10'h202, 8'hCC); preload(10'h203, 8'hDD);
    preload(10'h3FE, 8'h01); preload(10'h3FF, 8'h02); preload(10'h000, 8'h03); preload(10'h001, 8'h04);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0); chk("rst_done", 32'(done), 0); chk("rst_err", 32'(err), 0);
    chk("rst_rdata", rdata, 0); chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", mem_addr, 0); chk("rst_wdata", 32'(mem_wdata), 0);
    step();
    rst_n = 1'b1; m_rdata = '0; chk_en = 1'b1;
    step(); step();
    txn(0, 2'd0, 0, 32'h100, 0);
    chk("lb_pin", rdata, 32'hFFFFFF80);
    step();
    txn(0, 2'd1, 1, 32'h102, 0);
    chk("lhu_pin", rdata, 32'h00001234);
    step();
    txn(0, 2'd1, 0, 32'h104, 0);
    chk("lh_pin", rdata, 32'hFFFFFF80);
    step();
    txn(1, 2'd2, 0, 32'h79, 32'hDEADBEEF);
    step();
`ifdef LSU_MISALIGN_CHECK_EN
    chk("sw_pin", {ram[10'h7C], ram[10'h7B], ram[10'h7A], ram[10'h79]}, 32'h11111111);
`else
    chk("sw_pin", {ram[10'h7C], ram[10'h7B], ram[10'h7A], ram[10'h79]}, 32'hDEADBEEF);
`endif
    issue(1, 2'd0, 0, 32'h80, 32'h00000058, dc);
    step();
    step();
    issue(0, 2'd2, 0, 32'hFFFFFFFE, 0, dc);
    step();
    req = 1'b0;
    while (cyc < dc) step();
    chk("sb_pin", 32'(ram[10'h080]), 32'h58);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("lw_wrap_pin", rdata, 32'hFFFFFF80);
`else
    chk("lw_wrap_pin", rdata, 32'h04030201);
`endif
    step();
    issue(1, 2'd2, 0, 32'h200, 32'h11223344, dc);
    step();
    req = 1'b0;
    step(); step();
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0); chk("abort_done", 32'(done), 0); chk("abort_we", 32'(mem_we), 0);
    q.delete();
    @(negedge clk);
    chk("abort_mem", {ram[10'h203], ram[10'h202], ram[10'h201], ram[10'h200]}, 32'hDDCC3344);
    ref_mem[10'h202] = 8'hCC; ref_mem[10'h203] = 8'hDD;
    step();
    rst_n = 1'b1; m_rdata = '0; chk_en = 1'b1;
    step();
    txn(0, 2'd0, 1, 32'h100, 0);
    chk("lbu_pin", rdata, 32'h00000080);
    step();
    txn(0, 2'd3, 0, 32'h200, 0);
    chk("illegal_rdata_pin", rdata, 32'h00000080);
    step(); step(); step();
    chk_en = 1'b0;
    if (q.size() != 0) chk("queue_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Byte-serial load/store engine between the control FSM and the 8-bit `Ram` port. It executes RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW, one byte per clock, with a req/busy/done handshake. It replaces the fixed 32-bit-only `READ_MEMORY`/`WRITE_MEMORY` path in control. Loads return a sign- or zero-extended 32-bit word; stores write only the addressed bytes.

## Interface
- `ADDR_W`, default 32: address width of both the request port and the memory port.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `req  in  1`: start a transfer; sampled only when accept is possible.
- `write  in  1`: 1 = store, 0 = load.
- `width  in  2`: funct3[1:0] encoding; 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `is_unsigned  in  1`: funct3[2]; selects zero extension for loads; ignored for word loads and all stores.
- `addr  in  ADDR_W`: byte address, already computed by the ALU.
- `wdata  in  32`: store data; low bytes are used first.
- `busy  out  1`: transfer in progress; `req` is ignored while high.
- `done  out  1`: one-cycle pulse when a transfer completes.
- `rdata  out  32`: extended load result; held until the next load completes.
- `err  out  1`: qualifies `done`; high for an illegal width, or for misalignment when enabled.
- `mem_addr  out  ADDR_W`: byte address to `Ram`.
- `mem_we  out  1`: byte write strobe to `Ram`.
- `mem_wdata  out  8`: byte to `Ram`.
- `mem_rdata  in  8`: combinational read byte from `Ram`.

## Operation
- The FSM has three states: IDLE, XFER, DONE.
- A request is accepted when `req`=1 at a rising edge and the state is IDLE or DONE.
- On accept, the unit latches `addr`, `wdata`, `write`, `width` and `is_unsigned`, and clears the byte index to 0.
- Byte count n: 1 for byte, 2 for half, 4 for word.
- Accept of a legal request: state goes to XFER.
- Accept of an illegal request: state goes to DONE with `err`=1 and no memory access.
- In XFER, byte index i drives these memory outputs:
  - `mem_addr` = addr_q + i, computed modulo 2^ADDR_W, so the address wraps from all-ones to 0.
  - `mem_we` = write_q.
  - `mem_wdata` = wdata_q[8i +: 8].
- On a load, each edge stores `mem_rdata` into acc[8i +: 8].
- At the edge where i = n-1, the state moves to DONE; otherwise i increments.
- In DONE:
  - `done`=1 for exactly one cycle.
  - If the transfer was a load without `err`, `rdata` was updated at the DONE-entry edge.
  - Next state: XFER (or DONE) if a new request is accepted, else IDLE.
- Load extension (`rdata`):
  - byte: {24{sign}, b0}, where sign = b0[7] & ~is_unsigned.
  - half: {16{sign}, b1, b0}, where sign = b1[7] & ~is_unsigned.
  - word: {b3, b2, b1, b0}.
- Stores and errored transfers leave `rdata` unchanged.
- `busy` = (state == XFER).
- `mem_we` is 0 outside XFER; it is combinational from the state, so it drops immediately on reset.
- Reset values: state IDLE, `busy` 0, `done` 0, `err` 0, `rdata` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0.
- Reset mid-transfer aborts the transfer. Bytes already written stay written; no further bytes are written.

## Timing
- Cycle 0: `req` is high and accepted at the end-of-cycle edge.
- Cycles 1..n: byte i = 0..n-1 is on the memory bus in cycle i+1. A store byte commits at the edge ending that cycle.
- Cycle n+1: `done`=1. Load latency is therefore byte 2, half 3, word 5 cycles from `req` to `done`.
- Errored request: `done`/`err` are high in cycle 1, with no XFER cycle.
- A `req` held high during the DONE cycle is accepted at that cycle's edge, so back-to-back transfers have no idle bubble.
- `req` during XFER is dropped, not queued.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - A half access with addr[0]≠0, or a word access with addr[1:0]≠0, is rejected on accept.
  - The rejection behaves like an illegal width: `done`+`err` in cycle 1, no `mem_we`.
- `LSU_MISALIGN_CHECK_EN` undefined:
  - Misaligned accesses are performed byte-serially, including address wrap.
  - `err` is asserted only for width 11.

## Structure
- Shared package holds:
  - `MemWidth` enum (BITS8=2'b00, BITS16=2'b01, BITS32=2'b10), the same type used by `instr_stencil` funct3 decoding.
  - `LsuState` enum (IDLE, XFER, DONE).
- Sub-module `load_extender`: combinational; takes acc[31:0], width and is_unsigned, and produces the extended 32-bit word.
- The FSM, byte counter and latched request registers live in `load_store_unit`.

## Test plan
- Signed byte load: LB (width 00, is_unsigned 0) at 0x100 holding 0x80 → `rdata`=0xFFFFFF80, `done` in cycle 2, `busy` high in cycle 1 only.
- Half loads: memory 0x102/0x103 = 0x34/0x12; LHU → 0x00001234. Memory 0x80/0xFF; LH → 0xFFFFFF80.
- Word store: SW 0xDEADBEEF to 0x79 →
  - Without the macro: mem[0x79..0x7C] = EF BE AD DE and `done` in cycle 5.
  - With `LSU_MISALIGN_CHECK_EN`: `err`=1 and `done` in cycle 1, no `mem_we` pulse, memory unchanged.
- Back-to-back and wrap: SB 0x58 to 0x80 with `req` held through DONE, then LW at 0xFFFFFFFE → the second request is accepted at the DONE edge.
  - `mem_addr` sequence: FFFFFFFE, FFFFFFFF, 00000000, 00000001 (macro off).
- Reset and illegal width: deassert `rst_n` after 2 bytes of SW to 0x200 → `busy`/`done`/`mem_we` 0 immediately, 0x202/0x203 unchanged.
  - After release, width 11 → `err`=1 in cycle 1, no memory access, `rdata` unchanged.
